// File: rtl/i2c_pkg.sv
// Shared constants for the I2C master arbiter: word widths, FSM state encodings
// and a width helper for pointer and counter sizing.
package i2c_pkg;

  localparam int I2C_WORD_W   = 32;
  localparam int I2C_BYTEEN_W = 2;

  localparam logic [2:0] ST_ARB        = 3'd0;
  localparam logic [2:0] ST_ISSUE      = 3'd1;
  localparam logic [2:0] ST_WAIT_START = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE  = 3'd3;
  localparam logic [2:0] ST_DONE       = 3'd4;

  // Bits needed to index n items, never less than one.
  function automatic int ptr_width(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/i2c_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping
// around to index 0.
module rr_pick
  import i2c_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt_oh,
  output logic [PTR_W-1:0] gnt_idx,
  output logic             any
);

  // Scan from ptr with wrap and keep only the first hit.
  always_comb begin
    int idx_v;
    gnt_oh  = '0;
    gnt_idx = '0;
    any     = 1'b0;
    idx_v   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_v = int'(ptr) + k;
      if (idx_v >= N_REQ) begin
        idx_v = idx_v - N_REQ;
      end else begin
        idx_v = idx_v;
      end
      if (!any && req[idx_v]) begin
        any            = 1'b1;
        gnt_oh[idx_v]  = 1'b1;
        gnt_idx        = PTR_W'(idx_v);
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter serialising whole transactions from N_REQ requesters onto
// one I2C byte-engine master. Optional watchdog: `define I2C_ARB_TIMEOUT_EN.
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int START_WAIT     = 4,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [I2C_WORD_W*N_REQ-1:0] req_data,
  input  logic [2*N_REQ-1:0]          req_byteen,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            done,
  output logic [I2C_WORD_W-1:0]       rd_data,
  output logic                        err,
  output logic                        busy,
  output logic                        m_en,
  output logic [I2C_WORD_W-1:0]       m_data,
  output logic [I2C_BYTEEN_W-1:0]     m_byteEn,
  input  logic [I2C_WORD_W-1:0]       m_readData,
  input  logic                        m_idle
);

  localparam int PTR_W = ptr_width(N_REQ);
  localparam int SW_W  = ptr_width(START_WAIT + 1);

  if (N_REQ < 2 || N_REQ > 8 || START_WAIT < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("i2c_arbiter: parameter out of range");
  end

  logic [2:0]              state_r;
  logic [PTR_W-1:0]        ptr_r;
  logic [PTR_W-1:0]        win_idx_r;
  logic [N_REQ-1:0]        win_oh_r;
  logic [SW_W-1:0]         sw_cnt_r;
  logic [N_REQ-1:0]        gnt_r;
  logic [N_REQ-1:0]        done_r;
  logic [I2C_WORD_W-1:0]   rd_data_r;
  logic                    busy_r;
  logic                    m_en_r;
  logic [I2C_WORD_W-1:0]   m_data_r;
  logic [I2C_BYTEEN_W-1:0] m_byteen_r;

  logic [N_REQ-1:0]        pick_oh_s;
  logic [PTR_W-1:0]        pick_idx_s;
  logic                    pick_any_s;
  logic [I2C_WORD_W-1:0]   sel_data_s;
  logic [I2C_BYTEEN_W-1:0] sel_be_s;
  logic [PTR_W-1:0]        ptr_next_s;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [31:0] wd_r;
  logic        err_r;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req     (req),
    .ptr     (ptr_r),
    .gnt_oh  (pick_oh_s),
    .gnt_idx (pick_idx_s),
    .any     (pick_any_s)
  );

  // One-hot select of the winning requester's word and byte count.
  always_comb begin
    sel_data_s = '0;
    sel_be_s   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      sel_data_s = sel_data_s | ({I2C_WORD_W{pick_oh_s[i]}} & req_data[I2C_WORD_W*i +: I2C_WORD_W]);
      sel_be_s   = sel_be_s | ({I2C_BYTEEN_W{pick_oh_s[i]}} & req_byteen[I2C_BYTEEN_W*i +: I2C_BYTEEN_W]);
    end
  end

  // Pointer moves to the requester after the one just served.
  always_comb begin
    if (win_idx_r == PTR_W'(N_REQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = win_idx_r + PTR_W'(1);
    end
  end

  // Transaction FSM: grant, strobe, wait for master start and completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_ARB;
      ptr_r      <= '0;
      win_idx_r  <= '0;
      win_oh_r   <= '0;
      sw_cnt_r   <= '0;
      gnt_r      <= '0;
      done_r     <= '0;
      rd_data_r  <= '0;
      busy_r     <= 1'b0;
      m_en_r     <= 1'b0;
      m_data_r   <= '0;
      m_byteen_r <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      wd_r       <= 32'd0;
      err_r      <= 1'b0;
`endif
    end else begin
      gnt_r  <= '0;
      done_r <= '0;
      m_en_r <= 1'b0;
      case (state_r)
        ST_ARB: begin
          // The master has no reset, so never grant until it reports idle.
          if (m_idle && pick_any_s) begin
            m_data_r   <= sel_data_s;
            m_byteen_r <= sel_be_s;
            gnt_r      <= pick_oh_s;
            win_idx_r  <= pick_idx_s;
            win_oh_r   <= pick_oh_s;
            busy_r     <= 1'b1;
            state_r    <= ST_ISSUE;
          end else begin
            state_r <= ST_ARB;
          end
        end
        ST_ISSUE: begin
          m_en_r   <= 1'b1;
          sw_cnt_r <= '0;
          state_r  <= ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (!m_idle) begin
`ifdef I2C_ARB_TIMEOUT_EN
            wd_r    <= 32'd0;
`endif
            state_r <= ST_WAIT_DONE;
          end else if (sw_cnt_r == SW_W'(START_WAIT - 1)) begin
            state_r <= ST_ISSUE;
          end else begin
            sw_cnt_r <= sw_cnt_r + SW_W'(1);
          end
        end
        ST_WAIT_DONE: begin
          if (m_idle) begin
            rd_data_r <= m_readData;
            done_r    <= win_oh_r;
            ptr_r     <= ptr_next_s;
            state_r   <= ST_DONE;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (wd_r == 32'(TIMEOUT_CYCLES - 1)) begin
            rd_data_r <= 32'h0000_0000;
            done_r    <= win_oh_r;
            err_r     <= 1'b1;
            ptr_r     <= ptr_next_s;
            state_r   <= ST_DONE;
          end else begin
            wd_r <= wd_r + 32'd1;
          end
`else
          else begin
            state_r <= ST_WAIT_DONE;
          end
`endif
        end
        ST_DONE: begin
          busy_r  <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
          err_r   <= 1'b0;
`endif
          state_r <= ST_ARB;
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_ARB;
        end
      endcase
    end
  end

  assign gnt      = gnt_r;
  assign done     = done_r;
  assign rd_data  = rd_data_r;
  assign busy     = busy_r;
  assign m_en     = m_en_r;
  assign m_data   = m_data_r;
  assign m_byteEn = m_byteen_r;
`ifdef I2C_ARB_TIMEOUT_EN
  assign err      = err_r;
`else
  assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_i2c_arbiter.sv
// Scoreboard bench for i2c_arbiter with a behavioural I2C master model.
module tb_i2c_arbiter;

  localparam int N_REQ          = 4;
  localparam int START_WAIT     = 4;
  localparam int TIMEOUT_CYCLES = 100;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [N_REQ-1:0]      req;
  logic [32*N_REQ-1:0]   req_data;
  logic [2*N_REQ-1:0]    req_byteen;
  logic [N_REQ-1:0]      gnt;
  logic [N_REQ-1:0]      done;
  logic [31:0]           rd_data;
  logic                  err;
  logic                  busy;
  logic                  m_en;
  logic [31:0]           m_data;
  logic [1:0]            m_byteEn;
  logic [31:0]           m_readData = 32'h0;
  logic                  m_idle = 1'b1;

  i2c_arbiter #(
    .N_REQ          (N_REQ),
    .START_WAIT     (START_WAIT),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (req),
    .req_data   (req_data),
    .req_byteen (req_byteen),
    .gnt        (gnt),
    .done       (done),
    .rd_data    (rd_data),
    .err        (err),
    .busy       (busy),
    .m_en       (m_en),
    .m_data     (m_data),
    .m_byteEn   (m_byteEn),
    .m_readData (m_readData),
    .m_idle     (m_idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
    logic [1:0]  be;
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   cur_valid = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   gnt_cnt = 0;
  int   done_cnt = 0;
  int   men_cnt = 0;
  int   men_prev = -1000;
  int   men_gap = 0;
  int   cyc = 0;
  int   sb_ptr = 0;

  // Master model controls, written only by the stimulus process.
  logic        force_busy = 1'b0;
  int          ignore_at = -1;
  bit          rd_force_en = 0;
  logic [31:0] rd_force = 32'h0;
  // Master model state, written only by the model.
  int          men_total = 0;
  int          m_cnt = 0;
  logic [31:0] seen_data = 32'h0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, expv);
    end
  endtask

  // Behavioural byte engine: busy for a few cycles after a start strobe.
  always @(posedge clk) begin
    if (m_en) men_total <= men_total + 1;
    if (m_en && men_total == ignore_at) begin
      m_cnt <= m_cnt;
    end else if (m_en) begin
      m_idle    <= 1'b0;
      m_cnt     <= 3;
      seen_data <= m_data;
    end else if (force_busy) begin
      m_idle <= 1'b0;
    end else if (!m_idle) begin
      if (m_cnt == 0) begin
        m_idle     <= 1'b1;
        m_readData <= rd_force_en ? rd_force : (seen_data ^ 32'h5A5A_5A5A);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Output monitor: pops the scoreboard on gnt, checks m_en and done.
  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      cur_valid = 0;
    end else begin
      if (|gnt || |done || m_en)
        check_val("exclusive", 64'($countones({|gnt, |done, m_en})), 64'd1);
      if (|gnt) begin
        gnt_cnt++;
        if (exp_q.size() == 0) begin
          check_val("gnt_unexpected", 64'(gnt), 64'd0);
        end else begin
          check_val("gnt_outstanding", 64'(cur_valid), 64'd0);
          cur = exp_q.pop_front();
          cur_valid = 1;
          check_val("gnt_idx", 64'(gnt), 64'd1 << cur.idx);
          check_val("busy_at_gnt", 64'(busy), 64'd1);
        end
      end
      if (m_en) begin
        men_cnt++;
        men_gap  = cyc - men_prev;
        men_prev = cyc;
        if (!cur_valid) begin
          check_val("m_en_unexpected", 64'(m_en), 64'd0);
        end else begin
          check_val("m_data", 64'(m_data), 64'(cur.data));
          check_val("m_byteEn", 64'(m_byteEn), 64'(cur.be));
        end
      end
      if (|done) begin
        done_cnt++;
        if (!cur_valid) begin
          check_val("done_unexpected", 64'(done), 64'd0);
        end else begin
          check_val("done_idx", 64'(done), 64'd1 << cur.idx);
          check_val("rd_data", 64'(rd_data), 64'(cur.rd));
          check_val("err", 64'(err), 64'(cur.err));
          check_val("busy_at_done", 64'(busy), 64'd1);
          check_val("m_data_hold", 64'(m_data), 64'(cur.data));
          cur_valid = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    req = req & ~gnt;
  endtask

  task automatic load(input int i, input logic [31:0] d, input logic [1:0] be);
    req_data[32*i +: 32]  = d;
    req_byteen[2*i +: 2]  = be;
  endtask

  // Push expected grants in round-robin order from the model pointer, then raise reqs.
  task automatic push_set(input logic [N_REQ-1:0] mask, input logic exp_err);
    exp_t e;
    int   i;
    int   last;
    last = sb_ptr;
    for (int k = 0; k < N_REQ; k++) begin
      i = (sb_ptr + k) % N_REQ;
      if (mask[i]) begin
        e.idx  = i;
        e.data = req_data[32*i +: 32];
        e.be   = req_byteen[2*i +: 2];
        e.err  = exp_err;
        e.rd   = exp_err ? 32'h0 : (rd_force_en ? rd_force : (e.data ^ 32'h5A5A_5A5A));
        exp_q.push_back(e);
        last = i;
      end
    end
    sb_ptr = (last + 1) % N_REQ;
    req = req | mask;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cur_valid || req != '0) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) check_val("wait_budget", 64'd0, 64'd1);
  endtask

  task automatic wait_master_busy(input string tag);
    for (int n = 0; n < 50 && !(busy && !m_idle); n++) step();
    check_val(tag, 64'(busy && !m_idle), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int g0;
    int m0;
    int d0;
    req        = '0;
    req_data   = '0;
    req_byteen = '0;
    reset_n    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ctrl", 64'({gnt, done, err, busy, m_en}), 64'd0);
    check_val("rst_rd_data", 64'(rd_data), 64'd0);
    check_val("rst_m_data", 64'({m_byteEn, m_data}), 64'd0);
    reset_n = 1'b1;
    step();

    // All four at once from pointer 0: served 0,1,2,3.
    for (int i = 0; i < N_REQ; i++) load(i, 32'h1000_0000 * (i + 1) + 32'h55, 2'(i));
    push_set(4'b1111, 1'b0);
    run_until_idle(400);
    check_val("all4_gnts", 64'(gnt_cnt), 64'd4);
    check_val("all4_dones", 64'(done_cnt), 64'd4);

    // Single write transaction on requester 1.
    load(1, 32'h341E_A500, 2'd2);
    m0 = men_cnt;
    push_set(4'b0010, 1'b0);
    run_until_idle(200);
    check_val("single_m_en_pulses", 64'(men_cnt - m0), 64'd1);

    // Read transaction returning 0000BEEF.
    rd_force    = 32'h0000_BEEF;
    rd_force_en = 1;
    load(2, 32'h50A0_0100, 2'd1);
    push_set(4'b0100, 1'b0);
    run_until_idle(200);
    rd_force_en = 0;
    repeat (5) step();
    check_val("rd_data_hold", 64'(rd_data), 64'h0000_BEEF);

    // Master ignores the first strobe: arbiter re-issues after START_WAIT.
    ignore_at = men_total;
    load(3, 32'hC0DE_0042, 2'd3);
    m0 = men_cnt;
    push_set(4'b1000, 1'b0);
    run_until_idle(200);
    check_val("restrobe_pulses", 64'(men_cnt - m0), 64'd2);
    check_val("restrobe_gap", 64'(men_gap >= START_WAIT && men_gap <= START_WAIT + 2), 64'd1);

    // Request withdrawn before any grant while master is busy.
    force_busy = 1'b1;
    repeat (2) step();
    g0 = gnt_cnt;
    load(0, 32'hDEAD_0000, 2'd0);
    req[0] = 1'b1;
    repeat (8) step();
    req[0] = 1'b0;
    force_busy = 1'b0;
    repeat (10) step();
    check_val("withdrawn_no_gnt", 64'(gnt_cnt - g0), 64'd0);

    // Reset during WAIT_DONE: outputs clear at once, no done for the aborted txn.
    load(1, 32'h0BAD_F00D, 2'd2);
    push_set(4'b0010, 1'b0);
    wait_master_busy("reach_wait_done");
    force_busy = 1'b1;
    d0 = done_cnt;
    repeat (2) step();
    reset_n = 1'b0;
    #1;
    check_val("midrst_ctrl", 64'({gnt, done, err, busy, m_en}), 64'd0);
    check_val("midrst_m_data", 64'({m_byteEn, m_data}), 64'd0);
    exp_q.delete();
    sb_ptr = 0;
    repeat (2) step();
    reset_n = 1'b1;
    g0 = gnt_cnt;
    load(2, 32'h2222_3333, 2'd1);
    push_set(4'b0100, 1'b0);
    repeat (6) step();
    check_val("no_gnt_master_busy", 64'(gnt_cnt - g0), 64'd0);
    check_val("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    force_busy = 1'b0;
    run_until_idle(200);
    check_val("post_rst_gnt", 64'(gnt_cnt - g0), 64'd1);

`ifdef I2C_ARB_TIMEOUT_EN
    // Master stuck busy: watchdog completes with err and zero read data.
    load(0, 32'h7777_0001, 2'd2);
    push_set(4'b0001, 1'b1);
    wait_master_busy("timeout_wait_done");
    force_busy = 1'b1;
    d0 = done_cnt;
    run_until_idle(400);
    check_val("timeout_done", 64'(done_cnt - d0), 64'd1);
    force_busy = 1'b0;
    repeat (10) step();
`endif

    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
